// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one memory-controller port among N_REQ BUS masters.
// Optional grant lock for read-modify-write sequences: define BUS_ARBITER_LOCK_EN.
module bus_arbiter_rr #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_bus_en,
    input  logic [N_REQ-1:0]          i_wr_en,
    input  logic [N_REQ*XLEN-1:0]     i_wr_data,
    input  logic [N_REQ*XLEN-1:0]     i_addr,
    input  logic [N_REQ*4-1:0]        i_byte_en,
    input  logic [N_REQ-1:0]          i_atomic,
    input  logic [N_REQ*7-1:0]        i_operation,
`ifdef BUS_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]          i_lock,
`endif
    output logic [N_REQ-1:0]          o_ack,
    output logic [XLEN-1:0]           o_rd_data,
    output logic                      o_bus_en,
    output logic                      o_wr_en,
    output logic [XLEN-1:0]           o_wr_data,
    output logic [XLEN-1:0]           o_addr,
    output logic [3:0]                o_byte_en,
    output logic                      o_atomic,
    output logic [6:0]                o_operation,
    output logic [$clog2(N_REQ)-1:0]  o_id,
    input  logic                      i_ack,
    input  logic [XLEN-1:0]           i_rd_data
);

    localparam int unsigned IdW = $clog2(N_REQ);

`ifdef BUS_ARBITER_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {StIdle, StBusy, StLocked} state_e;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
`else
    typedef enum logic [0:0] {StIdle, StBusy} state_e;
`endif

    state_e state_q, state_d;

    logic [IdW-1:0]  last_q, last_d;
    logic [IdW-1:0]  id_q, id_d;
    logic            wr_en_q, wr_en_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      byte_en_q, byte_en_d;
    logic            atomic_q, atomic_d;
    logic [6:0]      operation_q, operation_d;

    logic            grant_valid;
    logic [IdW-1:0]  grant_idx;
    logic [IdW-1:0]  sel;
    logic            latch;

    // Scan last+1, last+2, ... modulo N_REQ; first requester found wins.
    always_comb begin
        int unsigned    cand;
        logic [IdW-1:0] cand_id;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand    = (32'(last_q) + off) % N_REQ;
            cand_id = IdW'(cand);
            if (!grant_valid && i_bus_en[cand_id]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        latch   = 1'b0;
        sel     = grant_idx;
`ifdef BUS_ARBITER_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    latch   = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (i_ack) begin
                    last_d  = id_q;
                    state_d = StIdle;
`ifdef BUS_ARBITER_LOCK_EN
                    if (i_lock[id_q]) begin
                        state_d    = StLocked;
                        lock_cnt_d = '0;
                    end
`endif
                end
            end
`ifdef BUS_ARBITER_LOCK_EN
            StLocked: begin
                // Only the lock owner is considered; no arbitration.
                if (i_bus_en[id_q]) begin
                    sel     = id_q;
                    latch   = 1'b1;
                    state_d = StBusy;
                end else if (!i_lock[id_q] || lock_cnt_q == CntW'(LOCK_MAX - 1)) begin
                    state_d = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        id_d        = id_q;
        wr_en_d     = wr_en_q;
        wr_data_d   = wr_data_q;
        addr_d      = addr_q;
        byte_en_d   = byte_en_q;
        atomic_d    = atomic_q;
        operation_d = operation_q;
        if (latch) begin
            id_d        = sel;
            wr_en_d     = i_wr_en[sel];
            wr_data_d   = i_wr_data[32'(sel) * XLEN +: XLEN];
            addr_d      = i_addr[32'(sel) * XLEN +: XLEN];
            byte_en_d   = i_byte_en[32'(sel) * 4 +: 4];
            atomic_d    = i_atomic[sel];
            operation_d = i_operation[32'(sel) * 7 +: 7];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            last_q      <= IdW'(N_REQ - 1);
            id_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            byte_en_q   <= '0;
            atomic_q    <= 1'b0;
            operation_q <= '0;
`ifdef BUS_ARBITER_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            byte_en_q   <= byte_en_d;
            atomic_q    <= atomic_d;
            operation_q <= operation_d;
`ifdef BUS_ARBITER_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        o_ack = '0;
        if (i_ack && state_q == StBusy) begin
            o_ack[id_q] = 1'b1;
        end
    end

    assign o_rd_data   = i_rd_data;
    assign o_bus_en    = (state_q == StBusy);
    assign o_wr_en     = wr_en_q;
    assign o_wr_data   = wr_data_q;
    assign o_addr      = addr_q;
    assign o_byte_en   = byte_en_q;
    assign o_atomic    = atomic_q;
    assign o_operation = operation_q;
    assign o_id        = id_q;

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter sharing one memory-controller port among `N_REQ` per-hart BUS masters in multi-hart tops. It generalises the fixed two-way sharing to N requesters. It registers the winning request, forwards it with the winner's ID (for the atomic reservation logic), and routes the downstream ack back. An optional lock keeps the grant across consecutive transactions of one hart so read-modify-write sequences are not interleaved.

## Interface
- `N_REQ`, 2: number of requesters; must be ≥2.
- `XLEN`, 32: data/address width.
- `LOCK_MAX`, 16: max idle cycles a lock may be held; only used with the lock feature.
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_bus_en` in N_REQ: per-requester request.
- `i_wr_en` in N_REQ: per-requester write.
- `i_wr_data` in N_REQ*XLEN: packed write data; requester k at [k*XLEN +: XLEN].
- `i_addr` in N_REQ*XLEN: packed address.
- `i_byte_en` in N_REQ*4: packed byte enables.
- `i_atomic` in N_REQ: atomic access flag.
- `i_operation` in N_REQ*7: packed funct7 of the atomic op.
- `i_lock` in N_REQ: hold-grant request; only with `BUS_ARBITER_LOCK_EN`.
- `o_ack` out N_REQ: one-hot ack to the granted requester.
- `o_rd_data` out XLEN: read data, broadcast to all requesters.
- `o_bus_en`, `o_wr_en` out 1: downstream request and write.
- `o_wr_data`, `o_addr` out XLEN: downstream write data and address.
- `o_byte_en` out 4: downstream byte enables.
- `o_atomic` out 1: downstream atomic flag.
- `o_operation` out 7: downstream funct7.
- `o_id` out $clog2(N_REQ): index of the granted requester.
- `i_ack` in 1: downstream ack.
- `i_rd_data` in XLEN: downstream read data.

## Operation
- **States:** IDLE, BUSY; with the lock feature also LOCKED.
- **Pointer:** `last` holds the most recent grant; it resets to N_REQ-1, so requester 0 wins first.
- **IDLE:**
  - If any `i_bus_en` is set, grant the first set bit scanning `last+1, last+2, …` modulo N_REQ.
  - Latch the winner's wr_en, wr_data, addr, byte_en, atomic and operation into the output registers; set `o_id` to the winner; go to BUSY.
  - With no request, remain in IDLE.
- **BUSY:**
  - `o_bus_en`=1; all latched outputs are held stable.
  - Changes on the inputs of any requester, including the granted one, are ignored.
  - On `i_ack`=1: `o_ack[o_id]`=1 combinationally in the same cycle; `last` <= `o_id`; next state is IDLE (or LOCKED, see Configuration).
- **Ack and data routing:**
  - `o_ack` = `i_ack` AND state==BUSY, decoded one-hot by `o_id`.
  - `o_rd_data` = `i_rd_data` at all times (combinational).
  - An `i_ack` arriving in IDLE or LOCKED is ignored and produces no `o_ack`.
- **Requester rule:** deassert `i_bus_en` in the cycle after `o_ack`. Requests are sampled only in IDLE or LOCKED.
- **Reset values:** `o_bus_en`, `o_wr_en`, `o_atomic`, `o_ack` = 0; `o_wr_data`, `o_addr` = 0; `o_byte_en`, `o_operation`, `o_id` = 0; `o_rd_data` follows `i_rd_data`.
- **Reset mid-transaction:** the state returns to IDLE immediately and `o_bus_en` drops. The in-flight downstream access is abandoned and no `o_ack` is issued.

## Timing
- **Grant latency:** a request seen in IDLE at edge n gives `o_bus_en`=1 from cycle n+1.
- **Ack:** zero-cycle pass-through.
- **Turnaround:** a downstream ack at cycle k gives `o_bus_en`=0 at k+1 (IDLE). The next grant's `o_bus_en` rises at k+2. Minimum spacing between two transactions is therefore 1 idle cycle.
- **Simultaneous requests:** priority rotates strictly. With N_REQ requesters all requesting continuously, each is served once every N_REQ transactions.

## Configuration
- Macro: `BUS_ARBITER_LOCK_EN`.
- **Defined:** the `i_lock` port exists.
  - On ack, if `i_lock[o_id]`=1, go to LOCKED instead of IDLE.
  - In LOCKED, only the owner's `i_bus_en` is considered. When it is set, latch that request and go to BUSY without arbitration.
  - Leave LOCKED for IDLE when the owner drops `i_lock`, or when a counter reaches `LOCK_MAX` idle cycles in LOCKED. The counter clears on entry to LOCKED and on reset.
  - `last` is not advanced while a lock is held.
- **Undefined:** the `i_lock` port and the LOCKED state are absent; behaviour is pure round-robin.

## Test plan
- **Reset:** assert `i_rst` mid-BUSY -> all outputs 0 the same cycle; after release, `i_bus_en`=01 -> `o_id`=0 with `o_bus_en`=1 one cycle later.
- **Simultaneous requests:** N_REQ=2, both requesting from reset, `i_ack` one cycle after each `o_bus_en` -> grant order 0,1,0,1; `o_ack` = 01,10,01,10; one idle cycle between transactions.
- **Data routing:** req1 write addr=0x100 data=0xDEADBEEF byte_en=0xF -> downstream fields match and `o_id`=1. Req0 read with `i_rd_data`=0x12345678 -> `o_ack`=01 and `o_rd_data`=0x12345678.
- **Spurious and stable:** `i_ack` pulse in IDLE -> `o_ack`=0. Changing the granted requester's inputs during BUSY -> outputs unchanged.
- **Lock, released normally (macro on):** req0 holds `i_lock` for LR then SC while req1 requests continuously -> both req0 transactions are served before req1's.
- **Lock, timeout (macro on):** req0 keeps `i_lock`=1 with no request -> after 16 cycles the arbiter is in IDLE and req1 is granted.
